// File: rtl/pmod_kpd_if.sv
// Pmod keypad pin bundle: four column drives, four row senses, decoded key outputs.
// No latency of its own; pure wiring between scanner and board.
// No backpressure; rows are level inputs, outputs are levels.
interface pmod_kpd_if;
  logic       J1;
  logic       J2;
  logic       J3;
  logic       J4;
  logic       J7;
  logic       J8;
  logic       J9;
  logic       J10;
  logic [3:0] outnum;
  logic       pressed;

  // scanner side
  modport master (
    output J1, J2, J3, J4, outnum, pressed,
    input  J7, J8, J9, J10
  );

  // board / keypad side
  modport slave (
    input  J1, J2, J3, J4, outnum, pressed,
    output J7, J8, J9, J10
  );
endinterface

// File: rtl/pmod_kpd.sv
// 4x4 Pmod keypad scanner: walks columns low one at a time, decodes first low row to a hex key.
// Latency: result applied on the edge ending a sweep (4*SCAN_CYCLES clocks), visible next cycle.
// No backpressure; optional debounce via macro PMOD_KPD_DEBOUNCE_EN (needs DEBOUNCE_SWEEPS equal sweeps).
module pmod_kpd #(
  parameter int SCAN_CYCLES     = 8,
  parameter int DEBOUNCE_SWEEPS = 3
) (
  input  logic        slow_clk,
  input  logic        rst,
  pmod_kpd_if.master  kpd
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (SCAN_CYCLES < 3) begin : g_scan_chk
    $error("SCAN_CYCLES must be 3 or more");
  end
  if (DEBOUNCE_SWEEPS < 1) begin : g_deb_chk
    $error("DEBOUNCE_SWEEPS must be 1 or more");
  end

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [1:0]    col;
  logic [SW-1:0] slot;
  logic          sweep_hit;
  logic [3:0]    sweep_code;
  logic          pressed_q;
  logic [3:0]    outnum_q;

  logic          slot_end;
  logic          sweep_end;
  logic          row_hit;
  logic [1:0]    row_first;
  logic [3:0]    key_code;
  logic          cur_hit;
  logic [3:0]    cur_code;

  assign slot_end  = (slot == SLOT_LAST);
  assign sweep_end = slot_end && (col == 2'd3);

  // Only the selected column is pulled low; the others idle high.
  assign kpd.J1 = (col != 2'd0);
  assign kpd.J2 = (col != 2'd1);
  assign kpd.J3 = (col != 2'd2);
  assign kpd.J4 = (col != 2'd3);

  assign kpd.outnum  = outnum_q;
  assign kpd.pressed = pressed_q;

  // Two-flop synchronizer on the asynchronous row lines (idle high).
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= {kpd.J10, kpd.J9, kpd.J8, kpd.J7};
      row_s2 <= row_s1;
    end
  end

  // Slot and column counters: dwell SCAN_CYCLES clocks per column, wrap after column 3.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      slot <= '0;
      col  <= 2'd0;
    end else if (slot_end) begin
      slot <= '0;
      col  <= col + 2'd1;
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Pick the lowest active row and map (row, column) to the printed key value.
  always_comb begin
    row_hit   = (row_s2 != 4'b1111);
    row_first = 2'd3;
    if (!row_s2[0])      row_first = 2'd0;
    else if (!row_s2[1]) row_first = 2'd1;
    else if (!row_s2[2]) row_first = 2'd2;
    key_code = 4'h0;
    case ({row_first, col})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hA;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hC;
      4'b11_00: key_code = 4'h0;
      4'b11_01: key_code = 4'hF;
      4'b11_10: key_code = 4'hE;
      default:  key_code = 4'hD;
    endcase
    // An earlier column's hit wins over anything seen in the current column.
    cur_hit  = sweep_hit || row_hit;
    cur_code = sweep_hit ? sweep_code : key_code;
  end

  // Accumulate the first hit of the sweep; cleared when the sweep closes.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      sweep_hit  <= 1'b0;
      sweep_code <= 4'h0;
    end else if (sweep_end) begin
      sweep_hit  <= 1'b0;
      sweep_code <= 4'h0;
    end else if (slot_end && !sweep_hit && row_hit) begin
      sweep_hit  <= 1'b1;
      sweep_code <= key_code;
    end
  end

`ifdef PMOD_KPD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SWEEPS);

  logic          cand_hit;
  logic [3:0]    cand_code;
  logic [CW-1:0] cand_cnt;
  logic [CW-1:0] cnt_next;
  logic          same;

  // Run length of identical sweep results; empty results match regardless of code.
  always_comb begin
    same = (cand_cnt != '0) && (cand_hit == cur_hit) && (!cur_hit || (cand_code == cur_code));
    if (!same)                   cnt_next = CW'(1);
    else if (cand_cnt >= CNT_MAX) cnt_next = CNT_MAX;
    else                         cnt_next = cand_cnt + CW'(1);
  end

  // Apply a sweep result only once it has repeated DEBOUNCE_SWEEPS times in a row.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      cand_hit  <= 1'b0;
      cand_code <= 4'h0;
      cand_cnt  <= '0;
      pressed_q <= 1'b0;
      outnum_q  <= 4'h0;
    end else if (sweep_end) begin
      cand_hit  <= cur_hit;
      cand_code <= cur_code;
      cand_cnt  <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        pressed_q <= cur_hit;
        if (cur_hit) outnum_q <= cur_code;
      end
    end
  end
`else
  // Apply every sweep result directly; outnum is held across release.
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      pressed_q <= 1'b0;
      outnum_q  <= 4'h0;
    end else if (sweep_end) begin
      pressed_q <= cur_hit;
      if (cur_hit) outnum_q <= cur_code;
    end
  end
`endif

endmodule

// File: tb/tb_pmod_kpd.sv
// Bench for pmod_kpd: keypad matrix model drives rows from held keys and live column drives.
// Reference model works per sweep from the key layout; checks every cycle after the edge.
// Directed cases followed by randomized key sets and mid-sweep resets.
module tb_pmod_kpd;
  localparam int S     = 4;
  localparam int DS    = 3;
  localparam int SWEEP = 4 * S;

  localparam logic [3:0] LAYOUT [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  logic slow_clk = 1'b0;
  logic rst      = 1'b1;

  pmod_kpd_if kpd ();

  pmod_kpd #(.SCAN_CYCLES(S), .DEBOUNCE_SWEEPS(DS)) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .kpd      (kpd)
  );

  always #5 slow_clk = ~slow_clk;

  logic [15:0] held = 16'h0;
  logic [3:0]  row_n;
  logic [3:0]  cols;

  assign cols = {kpd.J4, kpd.J3, kpd.J2, kpd.J1};

  // Keypad matrix: a held key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cols[c] && held[LAYOUT[r][c]]) row_n[r] = 1'b0;
  end

  assign kpd.J7  = row_n[0];
  assign kpd.J8  = row_n[1];
  assign kpd.J9  = row_n[2];
  assign kpd.J10 = row_n[3];

  int       n_pass = 0;
  int       n_chk  = 0;
  int       k      = 0;
  bit       exp_pressed = 1'b0;
  int       exp_outnum  = 0;
  int       hist[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, k);
  endtask

  // First held key in scan order: columns left to right, rows top to bottom.
  function automatic int sweep_result(input logic [15:0] h);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (h[LAYOUT[r][c]]) return int'(LAYOUT[r][c]);
    return -1;
  endfunction

  task automatic apply(input int res);
    bit ok;
`ifdef PMOD_KPD_DEBOUNCE_EN
    hist.push_back(res);
    if (hist.size() > DS) void'(hist.pop_front());
    ok = (hist.size() == DS);
    foreach (hist[i]) if (hist[i] != res) ok = 1'b0;
`else
    ok = 1'b1;
`endif
    if (ok) begin
      exp_pressed = (res >= 0);
      if (res >= 0) exp_outnum = res;
    end
  endtask

  // One clock: advance the model across the edge, then compare outputs just after it.
  task automatic step();
    bit in_rst;
    logic [3:0] exp_cols;
    in_rst = rst;
    @(posedge slow_clk);
    if (in_rst) begin
      k = 0;
      exp_pressed = 1'b0;
      exp_outnum  = 0;
      hist.delete();
    end else begin
      k++;
      if (k % SWEEP == 0) apply(sweep_result(held));
    end
    #1;
    exp_cols = 4'b1111;
    exp_cols[(k / S) % 4] = 1'b0;
    check("cols", int'(cols), int'(exp_cols));
    check("pressed", int'(kpd.pressed), int'(exp_pressed));
    check("outnum", int'(kpd.outnum), exp_outnum);
  endtask

  task automatic run_sweeps(input int n);
    repeat (n * SWEEP) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int mode;
    int a;
    int b;

    // Reset and idle scanning.
    rst = 1'b1;
    step();
    step();
    check("rst_pressed", int'(kpd.pressed), 0);
    check("rst_outnum", int'(kpd.outnum), 0);
    check("rst_J1", int'(kpd.J1), 0);
    rst = 1'b0;
    run_sweeps(2);
    check("idle_pressed", int'(kpd.pressed), 0);

    // Key 5 press and release.
    held = 16'h1 << 5;
    run_sweeps(DS + 1);
    check("k5_pressed", int'(kpd.pressed), 1);
    check("k5_outnum", int'(kpd.outnum), 5);
    held = 16'h0;
    run_sweeps(DS + 1);
    check("k5_rel_pressed", int'(kpd.pressed), 0);
    check("k5_rel_outnum", int'(kpd.outnum), 5);

    // Full key map.
    for (int v = 0; v < 16; v++) begin
      held = 16'h1 << v;
      run_sweeps(DS + 1);
      check("map", int'(kpd.outnum), v);
    end
    held = 16'h0;
    run_sweeps(DS + 1);

    // Two keys: scan order priority, then drop the winner.
    held = (16'h1 << 1) | (16'h1 << 5);
    run_sweeps(DS + 1);
    check("k1k5_outnum", int'(kpd.outnum), 1);
    held = 16'h1 << 5;
    run_sweeps(DS + 1);
    check("k5_only_outnum", int'(kpd.outnum), 5);
    check("k5_only_pressed", int'(kpd.pressed), 1);
    held = 16'h0;
    run_sweeps(DS + 1);

`ifdef PMOD_KPD_DEBOUNCE_EN
    // One-sweep glitch must not register; a steady key must.
    held = 16'h1 << 9;
    run_sweeps(1);
    held = 16'h0;
    run_sweeps(1);
    check("glitch_pressed", int'(kpd.pressed), 0);
    held = 16'h1 << 9;
    run_sweeps(DS);
    check("k9_pressed", int'(kpd.pressed), 1);
    check("k9_outnum", int'(kpd.outnum), 9);
    held = 16'h0;
    run_sweeps(DS + 1);
`endif

    // Reset while key 7 is reported, then re-report.
    held = 16'h1 << 7;
    run_sweeps(DS + 1);
    check("k7_outnum", int'(kpd.outnum), 7);
    repeat (5) step();
    do_reset();
    check("k7_rst_pressed", int'(kpd.pressed), 0);
    check("k7_rst_outnum", int'(kpd.outnum), 0);
    check("k7_rst_J1", int'(kpd.J1), 0);
    run_sweeps(DS + 1);
    check("k7_again_pressed", int'(kpd.pressed), 1);
    check("k7_again_outnum", int'(kpd.outnum), 7);

    // Randomized key sets, changed on sweep boundaries, with occasional mid-sweep resets.
    for (int it = 0; it < 60; it++) begin
      mode = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      case (mode)
        0: held = 16'h0;
        1: held = 16'h1 << a;
        2: held = (16'h1 << a) | (16'h1 << b);
        default: held = held;
      endcase
      run_sweeps($urandom_range(1, DS + 1));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, SWEEP - 1)) step();
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pmod_kpd.md
# pmod_kpd

Scanner and decoder for a 4x4 Pmod keypad (keys 0-9, A-F). It drives the four column lines one at a time and samples the four row lines. It reports the detected key as a 4-bit hex code with a `pressed` level. It sits below `keyboard_decoder`, which latches `outnum` on the falling edge of `pressed`, so `outnum` must stay valid after the key is released.

## Interface
- `SCAN_CYCLES`, default 8: clocks spent on each column; must be 3 or more.
- `DEBOUNCE_SWEEPS`, default 3: consecutive identical sweeps needed to change `pressed`/`outnum` (used only with debounce enabled).
- `slow_clk` input, 1 bit: the single clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `J7` input, 1 bit: row 0 (keys 1,2,3,A); active-low, pulled up on the board.
- `J8` input, 1 bit: row 1 (keys 4,5,6,B); active-low.
- `J9` input, 1 bit: row 2 (keys 7,8,9,C); active-low.
- `J10` input, 1 bit: row 3 (keys 0,F,E,D); active-low.
- `J1` output, 1 bit: column 0 drive (keys 1,4,7,0); driven low when selected.
- `J2` output, 1 bit: column 1 drive (keys 2,5,8,F).
- `J3` output, 1 bit: column 2 drive (keys 3,6,9,E).
- `J4` output, 1 bit: column 3 drive (keys A,B,C,D).
- `outnum` output, 4 bits: hex code of the last accepted key; held after release.
- `pressed` output, 1 bit: high while a key is accepted as held.

## Operation
- Rows pass through a 2-flop synchronizer before use.
- Column counter `col` runs 0..3 and slot counter runs 0..SCAN_CYCLES-1.
- Exactly one of J1..J4 is low at any time: the one selected by `col`.
- On the last cycle of a slot:
  - take the synchronized rows (the column has settled by then);
  - record the first low row;
  - advance `col`, wrapping from 3 to 0.
- One sweep is columns 0 through 3, i.e. 4*SCAN_CYCLES clocks.
- At the end of a sweep the sweep result is a hit with code K, or empty.
- Key codes are `outnum` = key value:
  - row 0: 1,2,3,A
  - row 1: 4,5,6,B
  - row 2: 7,8,9,C
  - row 3: 0,F,E,D
- Multiple keys: the first hit in scan order wins, column 0 first and lowest row first within a column. Example: 1 and 5 held gives 0x1.
- A hit updates `outnum` to K and sets `pressed` to 1.
- An empty sweep clears `pressed` to 0; `outnum` keeps its value.
- A key change while held (hit K1, then hit K2) updates `outnum`; `pressed` stays 1.

## Timing
- Reset values:
  - `pressed` = 0
  - `outnum` = 4'h0
  - `col` = 0, so J1=0 and J2=J3=J4=1
  - slot counter = 0
  - synchronizers = 4'b1111
  - debounce state cleared
- Reset during a sweep discards that partial sweep.
- `pressed` and `outnum` are registered and change only on the clock edge that ends a sweep. Both are visible in the following cycle.
- Latency without debounce: a key stable before a sweep starts is reported 1 cycle after that sweep ends, at most 8*SCAN_CYCLES+1 clocks.
- Release is reported the same way.
- `outnum` must be stable on the cycle `pressed` falls and on every cycle after it.

## Configuration
- Macro `PMOD_KPD_DEBOUNCE_EN`.
- Defined:
  - a sweep result (hit K or empty) must repeat for DEBOUNCE_SWEEPS consecutive sweeps before it is applied;
  - any differing sweep restarts the count at 1;
  - release therefore takes DEBOUNCE_SWEEPS empty sweeps.
- Undefined: every sweep result is applied immediately and `DEBOUNCE_SWEEPS` is ignored.

## Test plan
- Scanning, no key, SCAN_CYCLES=4:
  - column pattern {J4,J3,J2,J1} cycles 1110, 1101, 1011, 0111;
  - each pattern holds for 4 clocks;
  - `pressed` stays 0.
- Key 5 (J8 low while J2 low), debounce off:
  - after the next full sweep, `pressed`=1 and `outnum`=4'h5;
  - on release, `pressed`=0 one sweep later with `outnum` still 4'h5.
- Full key map: press each of the 16 keys in turn; `outnum` must equal the key's hex value (J10 with J1 gives 0x0, J10 with J4 gives 0xD).
- Keys 1 and 5 held together: `outnum`=4'h1. Then release key 1: `outnum`=4'h5 and `pressed` stays 1.
- Debounce on, DEBOUNCE_SWEEPS=3:
  - a 1-sweep glitch on key 9 leaves `pressed`=0;
  - key 9 held 3 sweeps gives `pressed`=1 and `outnum`=9.
- Assert `rst` while key 7 is reported: next cycle `pressed`=0, `outnum`=0, J1=0. After `rst` is released, key 7 is re-reported.
